// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receiver, transmitter and their FIFOs.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package uart_pkg;

    // Data bits per character, shared by receiver, transmitter and FIFOs
    localparam int UART_DBIT          = 8;
    // Oversampling ticks per stop bit, shared by receiver and transmitter
    localparam int UART_SB_TICK       = 16;
    // Default receive / transmit FIFO depths (entries, power of two)
    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_TX_FIFO_DEPTH = 16;

    // Pointer width for a FIFO of the given depth: address bits plus one wrap bit
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DBIT register array: synchronous write port, asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is legal. Storage is never reset.
module uart_fifo_mem #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DBIT-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DBIT-1:0] rdata
);

    logic [DBIT-1:0] mem_q [DEPTH];

    // Storage write; deliberately unreset so it maps onto plain flops / LUT RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between UART receiver and host; optional irq with `define UART_RX_FIFO_IRQ_EN.
// Latency: byte written at edge N is readable after edge N; rd_data is show-ahead of the head entry.
// Backpressure: none toward the receiver; a byte arriving while full (and not popped) is dropped and sets sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT      = UART_DBIT,
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,
    parameter int IRQ_LEVEL = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_done,
    input  logic [DBIT-1:0] rx_data,
    input  logic            rd_en,
    output logic [DBIT-1:0] rd_data,
    output logic            empty,
    output logic            full,
    output logic [AW:0]     count,
    output logic            overrun,
    input  logic            overrun_clr
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int PW = fifo_ptr_w(DEPTH);

    // Elaboration-time sanity checks on the configuration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
        $error("uart_rx_fifo: IRQ_LEVEL must be in 1..DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overrun_q, overrun_d;
    logic          empty_w, full_w;
    logic          pop, push, drop;

    // Occupancy flags from the wrap-bit pointer pair, and the accept/drop decisions
    always_comb begin
        empty_w = (wr_ptr_q == rd_ptr_q);
        full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop     = rd_en && !empty_w;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
        push    = rx_done && (!full_w || pop);
        drop    = rx_done && full_w && !pop;
    end

    // Next pointers and sticky overrun; a new drop wins over a same-cycle clear
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Pointer and overrun state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Status outputs; count wraps naturally modulo 2^(AW+1)
    always_comb begin
        empty   = empty_w;
        full    = full_w;
        count   = wr_ptr_q - rd_ptr_q;
        overrun = overrun_q;
    end

    uart_fifo_mem #(
        .DBIT  (DBIT),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [AW:0] IRQ_LVL = (AW + 1)'(IRQ_LEVEL);

    logic          irq_q, irq_d;
    logic [AW:0]   count_next;

    // Level irq computed from the post-edge fill level and overrun state
    always_comb begin
        count_next = wr_ptr_d - rd_ptr_d;
        irq_d      = (count_next >= IRQ_LVL) | overrun_d;
    end

    // Registered irq
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    // Drive the irq port
    always_comb begin
        irq = irq_q;
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, randomized traffic plus directed corner cases.
// Driver applies inputs just after each rising edge; monitor compares on the falling edge.
// Build with +define+UART_RX_FIFO_IRQ_EN to also check irq.
module tb_uart_rx_fifo;

    localparam int DEPTH     = 16;
    localparam int IRQ_LEVEL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
`ifdef UART_RX_FIFO_IRQ_EN
    logic       irq;
`endif

    uart_rx_fifo #(
        .DBIT      (8),
        .DEPTH     (DEPTH),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef UART_RX_FIFO_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_q[$];   // bytes the FIFO should be holding, head first
    logic [7:0] exp_q[$];     // bytes the host is expected to read, in order
    bit         model_ovr = 1'b0;
    bit         mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare flags against the model and every host read against the scoreboard
    always @(negedge clk) begin
        if (mon_en && rst) begin
            check("count",   32'(count),   32'(model_q.size()));
            check("empty",   32'(empty),   32'(model_q.size() == 0));
            check("full",    32'(full),    32'(model_q.size() == DEPTH));
            check("overrun", 32'(overrun), 32'(model_ovr));
`ifdef UART_RX_FIFO_IRQ_EN
            check("irq", 32'(irq), 32'((model_q.size() >= IRQ_LEVEL) || model_ovr));
`endif
            if (rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=0x%0h expected=no data at t=%0t", rd_data, $time);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // One clock of stimulus, then advance the reference model by the rules of the FIFO
    task automatic cycle(input bit d, input logic [7:0] data, input bit r, input bit c);
        int n;
        bit pop;
        rx_done     = d;
        rx_data     = data;
        rd_en       = r;
        overrun_clr = c;
        n = model_q.size();
        if (r && n > 0) exp_q.push_back(model_q[0]);
        @(posedge clk);
        #1;
        pop = r && (n > 0);
        if (pop) void'(model_q.pop_front());
        if (d && (n < DEPTH || pop)) model_q.push_back(data);
        if (d && n == DEPTH && !pop) model_ovr = 1'b1;
        else if (c)                  model_ovr = 1'b0;
        rx_done     = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; state must clear without a clock edge
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_empty",   32'(empty),   32'd1);
        check("rst_count",   32'(count),   32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_full",    32'(full),    32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
        check("rst_irq",     32'(irq),     32'd0);
`endif
        model_q.delete();
        exp_q.delete();
        model_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state before any clock edge
        #1;
        check("init_empty",   32'(empty),   32'd1);
        check("init_full",    32'(full),    32'd0);
        check("init_count",   32'(count),   32'd0);
        check("init_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Two bytes in, two out, order preserved
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, then overflow; the dropped byte must never appear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        // Set beats clear in the same cycle
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Write and pop together while full: accepted, no overrun
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Write and pop together while empty: write only; then pop on empty is ignored
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // irq threshold walk, overrun-driven irq, and clear
        for (int i = 0; i < IRQ_LEVEL; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized interleaving with alternating write-heavy / read-heavy phases
        for (int k = 0; k < 240; k++) begin
            int  wp;
            bit  d;
            bit  r;
            bit  c;
            if (k == 120) begin
                for (int j = 0; j < 3; j++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
                mid_reset();
            end
            wp = ((k / 30) % 2 == 0) ? 75 : 30;
            d  = ($urandom_range(99) < wp);
            r  = ($urandom_range(99) < (100 - wp));
            c  = ($urandom_range(99) < 5);
            cycle(d, 8'($urandom), r, c);
        end

        // Drain what is left so every stored byte is read back and compared
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
